// File: rtl/if_pkg.sv
// Shared defaults and the per-cycle action type for the pipelined fetch stage.
package if_pkg;

  localparam logic [31:0] IF_NOP_INSN_DEF = 32'h0000_0000;
  localparam logic [31:0] IF_RESET_PC_DEF = 32'd64;

  // One action per clock edge, in priority order from reset down to a plain fetch
  typedef enum logic [2:0] {
    IF_RESET    = 3'd0,
    IF_REDIRECT = 3'd1,
    IF_HOLD     = 3'd2,
    IF_BUBBLE   = 3'd3,
    IF_FETCH    = 3'd4
  } if_action_t;

endpackage

// File: rtl/if_pc_gen.sv
// PC register with the next-PC priority mux; redirect targets are forced onto a
// PC_STEP boundary before they are loaded.
module if_pc_gen
  import if_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IF_RESET_PC_DEF),
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_stall,
  input  logic            i_control_j,
  input  logic [XLEN-1:0] i_pc_j,
  input  logic            i_ins_ready,
  output logic [XLEN-1:0] o_pc,
  output if_action_t      o_action
);

  localparam logic [XLEN-1:0] AlignMask = ~(XLEN'(PC_STEP - 1));

  logic [XLEN-1:0] r_pc;
  if_action_t      w_action;

  always_comb begin
    if (reset)             w_action = IF_RESET;
    else if (i_control_j)  w_action = IF_REDIRECT;
    else if (i_stall)      w_action = IF_HOLD;
    else if (!i_ins_ready) w_action = IF_BUBBLE;
    else                   w_action = IF_FETCH;
  end

  // Hold and bubble both keep the PC so the same address is refetched
  always_ff @(posedge clk) begin
    case (w_action)
      IF_RESET:    r_pc <= RESET_PC;
      IF_REDIRECT: r_pc <= i_pc_j & AlignMask;
      IF_FETCH:    r_pc <= r_pc + XLEN'(PC_STEP);
      default:     r_pc <= r_pc;
    endcase
  end

  assign o_pc     = r_pc;
  assign o_action = w_action;

endmodule

// File: rtl/if_stage_pipelined.sv
// Pipelined instruction-fetch stage: PC generation plus registered IF/ID outputs.
// Define IF_PERF_CNT_EN to add saturating fetch_cnt / bubble_cnt counters.
module if_stage_pipelined
  import if_pkg::*;
#(
  parameter int unsigned       XLEN     = 32,
  parameter int unsigned       INSN_W   = 32,
  parameter logic [XLEN-1:0]   RESET_PC = XLEN'(IF_RESET_PC_DEF),
  parameter int unsigned       PC_STEP  = 4,
  parameter logic [INSN_W-1:0] NOP_INSN = INSN_W'(IF_NOP_INSN_DEF),
  parameter int unsigned       CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              control_j,
  input  logic [XLEN-1:0]   pc_j,
  input  logic [INSN_W-1:0] ins_data,
  input  logic              ins_ready,
  output logic [XLEN-1:0]   ins_addr,
  output logic [XLEN-1:0]   pipe_pc,
  output logic [XLEN-1:0]   pipe_pc4,
  output logic [INSN_W-1:0] pipe_data,
  output logic              pipe_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  fetch_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  if (CNT_W < 1 || (PC_STEP & (PC_STEP - 1)) != 0) begin : g_bad_config
    $error("if_stage_pipelined: PC_STEP must be a power of two and CNT_W at least 1");
  end

  logic [XLEN-1:0]   w_pc;
  logic [XLEN-1:0]   w_pc_seq;
  if_action_t        w_action;
  logic [XLEN-1:0]   r_pipe_pc;
  logic [XLEN-1:0]   r_pipe_pc4;
  logic [INSN_W-1:0] r_pipe_data;
  logic              r_pipe_valid;

  if_pc_gen #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_gen (
    .clk         (clk),
    .reset       (reset),
    .i_stall     (stall),
    .i_control_j (control_j),
    .i_pc_j      (pc_j),
    .i_ins_ready (ins_ready),
    .o_pc        (w_pc),
    .o_action    (w_action)
  );

  assign w_pc_seq = w_pc + XLEN'(PC_STEP);

  // Redirects and memory-not-ready both record the current PC with a NOP bubble
  always_ff @(posedge clk) begin
    case (w_action)
      IF_RESET: begin
        r_pipe_pc    <= RESET_PC;
        r_pipe_pc4   <= RESET_PC + XLEN'(PC_STEP);
        r_pipe_data  <= NOP_INSN;
        r_pipe_valid <= 1'b0;
      end
      IF_REDIRECT, IF_BUBBLE: begin
        r_pipe_pc    <= w_pc;
        r_pipe_pc4   <= w_pc_seq;
        r_pipe_data  <= NOP_INSN;
        r_pipe_valid <= 1'b0;
      end
      IF_FETCH: begin
        r_pipe_pc    <= w_pc;
        r_pipe_pc4   <= w_pc_seq;
        r_pipe_data  <= ins_data;
        r_pipe_valid <= 1'b1;
      end
      default: begin
        r_pipe_pc    <= r_pipe_pc;
        r_pipe_pc4   <= r_pipe_pc4;
        r_pipe_data  <= r_pipe_data;
        r_pipe_valid <= r_pipe_valid;
      end
    endcase
  end

  assign ins_addr   = w_pc;
  assign pipe_pc    = r_pipe_pc;
  assign pipe_pc4   = r_pipe_pc4;
  assign pipe_data  = r_pipe_data;
  assign pipe_valid = r_pipe_valid;

`ifdef IF_PERF_CNT_EN
  logic [CNT_W-1:0] r_fetch_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  // Both counters stick at all-ones; stall edges touch neither
  always_ff @(posedge clk) begin
    if (w_action == IF_RESET) begin
      r_fetch_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_action == IF_FETCH && r_fetch_cnt != '1)
        r_fetch_cnt <= r_fetch_cnt + 1'b1;
      if ((w_action == IF_REDIRECT || w_action == IF_BUBBLE) && r_bubble_cnt != '1)
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign fetch_cnt  = r_fetch_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
